pc_fetch_unit: RTL



---
 rtl/mips_fetch_pkg.sv | 18 +
 rtl/pc_next_sel.sv | 33 +++
 rtl/pc_fetch_unit.sv | 101 ++++++++++
 3 files changed

// File: rtl/mips_fetch_pkg.sv
// Shared fetch-side types and program-window constants for the Group-15 program memory.
package mips_fetch_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  localparam int unsigned GROUP_ID    = 15;
  localparam logic [31:0] PROG_WINDOW = 32'h350;
  localparam logic [31:0] PROG_BASE   = GROUP_ID * PROG_WINDOW;
  localparam int unsigned PROG_DEPTH  = 1024;
  localparam logic [31:0] PROG_LAST   = PROG_BASE + PROG_DEPTH - 1;

  localparam logic [31:0] DEFAULT_PC_STEP = 32'd1;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC selection: stall > jump > branch > sequential, plus window check.
module pc_next_sel
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] PC_STEP     = DEFAULT_PC_STEP,
  parameter logic [31:0] WINDOW_BASE = PROG_BASE,
  parameter logic [31:0] WINDOW_LAST = PROG_LAST
) (
  input  logic [31:0] pc_i,
  input  logic        stall_i,
  input  logic        jump_en_i,
  input  logic [31:0] jump_target_i,
  input  logic        branch_en_i,
  input  logic [31:0] branch_offset_i,
  output logic [31:0] next_pc_o,
  output logic        out_of_window_o
);

  always_comb begin
    next_pc_o = pc_i + PC_STEP;
    if (stall_i) begin
      next_pc_o = pc_i;
    end else if (jump_en_i) begin
      next_pc_o = jump_target_i;
    end else if (branch_en_i) begin
      // Two's-complement add; modulo 2^32 wrap is intentional.
      next_pc_o = pc_i + branch_offset_i;
    end
  end

  assign out_of_window_o = (next_pc_o < WINDOW_BASE) || (next_pc_o > WINDOW_LAST);

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter / fetch sequencer feeding the program-memory address decoder.
// Optional window check enabled by defining PC_BOUNDS_CHECK_EN.
module pc_fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h31B0,
  parameter logic [31:0] PC_STEP      = DEFAULT_PC_STEP,
  parameter logic [31:0] PROG_BASE    = 32'h31B0,
  parameter logic [31:0] PROG_LAST    = 32'h35AF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_in,
  input  logic        branch_en,
  input  logic [31:0] branch_offset,
  input  logic        jump_en,
  input  logic [31:0] jump_target,
  output logic [31:0] pc_out,
  output logic [31:0] pc_seq_out,
  output logic        fetch_valid,
  output logic        fault,
  output logic [31:0] fetch_count
);

`ifdef PC_BOUNDS_CHECK_EN
  localparam bit BoundsCheckEn = 1'b1;
`else
  localparam bit BoundsCheckEn = 1'b0;
`endif

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  count_q, count_d;
  logic         fault_q, fault_d;

  logic [31:0]  next_pc;
  logic         out_of_window;
  logic         bounds_trip;

  pc_next_sel #(
    .PC_STEP     (PC_STEP),
    .WINDOW_BASE (PROG_BASE),
    .WINDOW_LAST (PROG_LAST)
  ) u_next_sel (
    .pc_i            (pc_q),
    .stall_i         (stall_in),
    .jump_en_i       (jump_en),
    .jump_target_i   (jump_target),
    .branch_en_i     (branch_en),
    .branch_offset_i (branch_offset),
    .next_pc_o       (next_pc),
    .out_of_window_o (out_of_window)
  );

  // With the check compiled out this folds to 0, leaving fault_q stuck at reset value.
  assign bounds_trip = BoundsCheckEn && out_of_window;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    fault_d = fault_q;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (!stall_in) begin
          if (bounds_trip) begin
            fault_d = 1'b1;
            state_d = HALT;
          end else begin
            pc_d    = next_pc;
            count_d = count_q + 32'd1;
          end
        end
      end
      HALT: ;
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      count_q <= 32'd0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      fault_q <= fault_d;
    end
  end

  assign pc_out      = pc_q;
  assign pc_seq_out  = pc_q + PC_STEP;
  assign fetch_valid = (state_q == RUN);
  assign fault       = fault_q;
  assign fetch_count = count_q;

endmodule
